// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and status flag positions shared by the ALU block
package alu_seq_pkg;
    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request and result handshake bundle between producer/consumer and ALU
interface alu_seq_if #(parameter int WIDTH = 32) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_cmd;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       status;
    logic             illegal;
    modport master (
        output in_valid, alu_cmd, in1, in2, c_in, out_ready,
        input  in_ready, out_valid, result, status, illegal
    );
    modport slave (
        input  in_valid, alu_cmd, in1, in2, c_in, out_ready,
        output in_ready, out_valid, result, status, illegal
    );
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per enabled cycle
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    // product already includes this cycle's partial sum so the last step can be registered directly
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done = en && cnt == '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (start) begin
            cnt    <= CW'(WIDTH - 1);
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (en) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt != '0 ? cnt - CW'(1) : cnt;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/NZVC flags and an iterative multiply
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1
) (
    input logic       clk,
    input logic       rst,
    alu_seq_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       st_q;
    logic             ill_q;
    logic [WIDTH-1:0] res_c;
    logic [3:0]       st_c;
    logic             ill_c;
    logic             sub;
    logic             arith;
    logic             cin;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   sum;
    logic             mul_done;
    logic [WIDTH-1:0] product;
    wire is_mul = MUL_EN && bus.alu_cmd == OP_MUL;
    wire accept = state == IDLE && bus.in_valid;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk(clk),
        .rst(rst),
        .start(accept && is_mul),
        .en(state == BUSY),
        .a(bus.in1),
        .b(bus.in2),
        .done(mul_done),
        .product(product)
    );
    // subtraction is in1 + ~in2 + cin, so V reduces to the same sign test as addition
    always_comb begin
        sub   = bus.alu_cmd == OP_SUB || bus.alu_cmd == OP_SBC;
        arith = sub || bus.alu_cmd == OP_ADD || bus.alu_cmd == OP_ADC;
        cin   = (bus.alu_cmd == OP_ADC || bus.alu_cmd == OP_SBC) ? bus.c_in : sub;
        opb   = sub ? ~bus.in2 : bus.in2;
        sum   = {1'b0, bus.in1} + {1'b0, opb} + (WIDTH + 1)'(cin);
        ill_c = 1'b0;
        case (bus.alu_cmd)
            OP_MOV:                         res_c = bus.in1;
            OP_MVN:                         res_c = ~bus.in1;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: res_c = sum[WIDTH-1:0];
            OP_AND:                         res_c = bus.in1 & bus.in2;
            OP_ORR:                         res_c = bus.in1 | bus.in2;
            OP_EOR:                         res_c = bus.in1 ^ bus.in2;
            default: begin
                res_c = '0;
                ill_c = 1'b1;
            end
        endcase
        st_c[FLAG_N] = res_c[WIDTH-1];
        st_c[FLAG_Z] = ~|res_c;
        st_c[FLAG_V] = arith && bus.in1[WIDTH-1] == opb[WIDTH-1] && res_c[WIDTH-1] != bus.in1[WIDTH-1];
        st_c[FLAG_C] = arith && sum[WIDTH];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            res_q <= '0;
            st_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (is_mul) begin
                        state <= BUSY;
                    end else begin
                        res_q <= res_c;
                        st_q  <= st_c;
                        ill_q <= ill_c;
                        state <= DONE;
                    end
                end
                BUSY: if (mul_done) begin
                    res_q <= product;
                    st_q  <= {product[WIDTH-1], ~|product, 2'b00};
                    ill_q <= 1'b0;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.result    = res_q;
    assign bus.status    = st_q;
    assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq handshake, flags, multiply timing, backpressure and reset
module tb_alu_seq;
    import alu_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(32)) bus0 ();
    alu_seq #(.WIDTH(32), .MUL_EN(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
    alu_seq #(.WIDTH(32), .MUL_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic ci);
        bus.alu_cmd  = cmd;
        bus.in1      = a;
        bus.in2      = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask
    task automatic release_out();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask
    task automatic run1(input string tag, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic [31:0] exp_res, input logic [3:0] exp_st, input logic exp_ill);
        issue(cmd, a, b, ci);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        check({tag, "_status"}, 64'(bus.status), 64'(exp_st));
        check({tag, "_illegal"}, 64'(bus.illegal), 64'(exp_ill));
        release_out();
    endtask
    initial begin
        logic bad;
        bus.in_valid = 1'b0; bus.alu_cmd = '0; bus.in1 = '0; bus.in2 = '0; bus.c_in = 1'b0; bus.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.alu_cmd = '0; bus0.in1 = '0; bus0.in2 = '0; bus0.c_in = 1'b0; bus0.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_status", 64'(bus.status), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);
        rst = 1'b1;
        tick();
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
        check("add_valid_lat1", 64'(bus.out_valid), 64'd1);
        check("add_in_ready", 64'(bus.in_ready), 64'd0);
        check("add_result", 64'(bus.result), 64'h8000_0000);
        check("add_status", 64'(bus.status), 64'b1010);
        release_out();
        check("add_back_idle", 64'(bus.in_ready), 64'd1);
        run1("sub_eq", OP_SUB, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0101, 1'b0);
        run1("sbc", OP_SBC, 32'd5, 32'd3, 1'b0, 32'd1, 4'b0001, 1'b0);
        run1("sub_neg", OP_SUB, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 4'b1000, 1'b0);
        run1("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b0);
        run1("adc_wrap", OP_ADC, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 4'b0101, 1'b0);
        run1("mvn", OP_MVN, 32'd0, 32'd7, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        run1("mov", OP_MOV, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 4'b0000, 1'b0);
        run1("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 32'h00F0_1234, 4'b0000, 1'b0);
        run1("orr", OP_ORR, 32'h8000_0000, 32'h1, 1'b0, 32'h8000_0001, 4'b1000, 1'b0);
        run1("illegal_op", 4'b0000, 32'd9, 32'd9, 1'b0, 32'd0, 4'b0100, 1'b1);
        // multiply: busy for 32 cycles, result on cycle 33
        issue(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
        bus.in1 = 32'hDEAD_BEEF;
        bus.in2 = 32'h1357_9BDF;
        bad = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        check("mul_busy_window", 64'(bad), 64'd0);
        check("mul_valid_c33", 64'(bus.out_valid), 64'd1);
        check("mul_result", 64'(bus.result), 64'hFFFF_FFFF);
        check("mul_status", 64'(bus.status), 64'b1000);
        release_out();
        issue(OP_MUL, 32'd3, 32'd5, 1'b0);
        bus.in1 = 32'hFFFF_FFFF;
        bus.in2 = 32'hFFFF_FFFF;
        bus.alu_cmd = OP_ADD;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 32; i++) tick();
        bus.in_valid = 1'b0;
        check("mul_capt_valid", 64'(bus.out_valid), 64'd1);
        check("mul_capt_result", 64'(bus.result), 64'd15);
        check("mul_capt_status", 64'(bus.status), 64'b0000);
        release_out();
        bus0.alu_cmd = OP_MUL;
        bus0.in1 = 32'h0000_FFFF;
        bus0.in2 = 32'h0001_0001;
        bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        check("nomul_valid", 64'(bus0.out_valid), 64'd1);
        check("nomul_illegal", 64'(bus0.illegal), 64'd1);
        check("nomul_result", 64'(bus0.result), 64'd0);
        check("nomul_status", 64'(bus0.status), 64'b0100);
        // backpressure holds the EOR result for five cycles
        issue(OP_EOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'h0F0F_0F0F) bad = 1'b1;
            tick();
        end
        check("bp_hold", 64'(bad), 64'd0);
        check("bp_result", 64'(bus.result), 64'h0F0F_0F0F);
        release_out();
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        issue(OP_MUL, 32'd7, 32'd9, 1'b0);
        for (int i = 1; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        check("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
        check("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid_result", 64'(bus.result), 64'd0);
        rst = 1'b1;
        tick();
        run1("adc_after_rst", OP_ADC, 32'd1, 32'd1, 1'b1, 32'd3, 4'b0000, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
